// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit two's-complement to 4-digit sign/magnitude BCD converter (double dabble).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (4'hF) in the result.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dig3,
  output logic [3:0]  dig2,
  output logic [3:0]  dig1,
  output logic [3:0]  dig0,
  output logic        neg,
  output logic        ovf
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  val_q, val_d;
  logic        [DATA_W:0]    mag_q, mag_d;
  logic        [19:0]        acc_q, acc_d;
  logic        [3:0]         cnt_q, cnt_d;
  logic                      sign_q, sign_d;

  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic        [15:0]        dig_q, dig_d;
  logic                      neg_q, neg_d;
  logic                      ovf_q, ovf_d;

  // 17 bits so that |-32768| is representable.
  function automatic logic [DATA_W:0] abs17(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W:0] ext;
    ext = {v[DATA_W-1], v};
    if (ext < 0) return $unsigned(-ext);
    return $unsigned(ext);
  endfunction

  function automatic logic [19:0] dabble_adjust(input logic [19:0] a);
    logic [19:0] r;
    r = a;
    for (int i = 0; i < 5; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Units digit is never blanked so a zero result still shows "0".
  function automatic logic [15:0] blank_leading(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (d[15:12] == 4'd0) begin
      r[15:12] = 4'hF;
      if (d[11:8] == 4'd0) begin
        r[11:8] = 4'hF;
        if (d[7:4] == 4'd0) r[7:4] = 4'hF;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dig_d   = dig_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mag_d   = abs17(val_q);
        sign_d  = val_q[DATA_W-1];
        acc_d   = 20'd0;
        cnt_d   = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = (dabble_adjust(acc_q) << 1) | {19'd0, mag_q[DATA_W-1]};
        mag_d = mag_q << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
        neg_d  = sign_q;
        if (acc_q[19:16] != 4'd0) begin
          ovf_d = 1'b1;
          dig_d = 16'hEEEE;
        end else begin
          ovf_d = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
          dig_d = blank_leading(acc_q[15:0]);
`else
          dig_d = acc_q[15:0];
`endif
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= 16'd0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dig_q   <= dig_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  // Datapath registers carry no reset; they are reloaded before use.
  always_ff @(posedge clk) begin
    val_q  <= val_d;
    mag_q  <= mag_d;
    acc_q  <= acc_d;
    sign_q <= sign_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dig3 = dig_q[15:12];
  assign dig2 = dig_q[11:8];
  assign dig1 = dig_q[7:4];
  assign dig0 = dig_q[3:0];
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard testbench for bin2bcd_seq; expected results come from an arithmetic reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        busy, done, neg, ovf;
  logic [3:0]  dig3, dig2, dig1, dig0;

  bin2bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .dig3  (dig3),
    .dig2  (dig2),
    .dig1  (dig1),
    .dig0  (dig0),
    .neg   (neg),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        n;
    logic        o;
    int          k;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [15:0] last_d = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] v);
    exp_t e;
    int   sv, m, a3, a2, a1, a0;
    sv = int'($signed(v));
    m  = (sv < 0) ? -sv : sv;
    e.n = v[15];
    e.o = (m > 9999);
    e.k = 0;
    if (e.o) begin
      e.d = 16'hEEEE;
    end else begin
      a3 = (m / 1000) % 10;
      a2 = (m / 100) % 10;
      a1 = (m / 10) % 10;
      a0 = m % 10;
      e.d = {a3[3:0], a2[3:0], a1[3:0], a0[3:0]};
`ifdef LEADING_ZERO_BLANK_EN
      if (e.d[15:12] == 4'd0) begin
        e.d[15:12] = 4'hF;
        if (e.d[11:8] == 4'd0) begin
          e.d[11:8] = 4'hF;
          if (e.d[7:4] == 4'd0) e.d[7:4] = 4'hF;
        end
      end
`endif
    end
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest pending conversion.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("latency", 32'(cyc - e.k), 32'd18);
        chk("digits",  32'({dig3, dig2, dig1, dig0}), 32'(e.d));
        chk("neg",     32'(neg), 32'(e.n));
        chk("ovf",     32'(ovf), 32'(e.o));
        chk("busy_at_done", 32'(busy), 32'd0);
        last_d = e.d;
      end
    end
  end

  // Drive a start for the next edge; returns at the negedge after that edge.
  task automatic start_conv(input logic [15:0] v, input bit accept);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    value = v;
    if (accept) begin
      e   = model(v);
      e.k = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_neg"},  32'(neg),  32'd0);
    chk({tag, "_ovf"},  32'(ovf),  32'd0);
    chk({tag, "_dig"},  32'({dig3, dig2, dig1, dig0}), 32'd0);
  endtask

  initial begin
    logic [15:0] vals [8];
    int          n;
    exp_t        e;
    vals = '{16'hFFD6, 16'd0, 16'd10000, 16'h8000, 16'd9999, 16'd32767, 16'hFFFF, 16'd100};

    rst   = 1'b1;
    start = 1'b0;
    value = 16'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    // Reset must win over a simultaneous start.
    start = 1'b1;
    value = 16'd55;
    @(negedge clk);
    chk("rst_over_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    // 1234 with busy window and output hold during conversion.
    start_conv(16'd1234, 1'b1);
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      chk("busy_window", 32'(busy), 32'd1);
      if (j == 9) chk("hold_during_busy", 32'({dig3, dig2, dig1, dig0}), 32'(last_d));
    end
    wait_empty();

    foreach (vals[i]) begin
      start_conv(vals[i], 1'b1);
      wait_empty();
    end
    repeat (3) @(negedge clk);
    chk("hold_idle", 32'({dig3, dig2, dig1, dig0}), 32'(last_d));

    // Start during busy ignored; start in the done cycle accepted.
    start_conv(16'd1234, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    value = 16'd99;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    start = 1'b1;
    value = 16'd500;
    e   = model(16'd500);
    e.k = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_b2b", 32'(busy), 32'd1);
    wait_empty();

    // Reset at edge k+9 aborts the conversion.
    start_conv(16'd1234, 1'b1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("abort");
    last_d = 16'd0;
    repeat (25) @(negedge clk);
    chk("abort_no_done_busy", 32'(busy), 32'd0);
    start_conv(16'd77, 1'b1);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
